// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB master arbiter with a per-tenure beat budget.
// Drives a one-hot grant and tracks the address-phase and data-phase owners.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int DEFAULT_MASTER  = 0,
    parameter int MAX_GRANT_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         Bus_Req,
    input  logic [1:0]                     HTrans,
    input  logic                           HReady,
    output logic [NUM_MASTERS-1:0]         Bus_Grant,
    output logic [$clog2(NUM_MASTERS)-1:0] HMaster,
    output logic [$clog2(NUM_MASTERS)-1:0] HMaster_Data,
    output logic                           Parked
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = 8;

    localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT   = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [CNT_W-1:0]       MAX_BEATS = CNT_W'(MAX_GRANT_BEATS);

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic {
        PARK  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]       hmaster_q, hmaster_d;
    logic [IDX_W-1:0]       hmaster_data_q, hmaster_data_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

    logic             beat_valid;
    logic             budget_spent;
    logic             rearb;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;

    assign beat_valid   = (HTrans == HTRANS_NONSEQ) || (HTrans == HTRANS_SEQ);
    assign budget_spent = (beat_cnt_q == MAX_BEATS);
    assign rearb        = HReady && ((state_q == PARK) || !Bus_Req[hmaster_q] || budget_spent);

    // Search starts just past the last winner; the last winner itself is
    // visited last, so an exhausted owner is re-granted only when alone.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        win_found = 1'b0;
        win_idx   = DEF_IDX;
        cand_idx  = DEF_IDX;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + off) % NUM_MASTERS);
            if (!win_found && Bus_Req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        gnt_idx_d      = gnt_idx_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        rr_ptr_d       = rr_ptr_q;
        beat_cnt_d     = beat_cnt_q;

        // Wait states freeze the whole arbiter.
        if (HReady) begin
            hmaster_d      = gnt_idx_q;
            hmaster_data_d = hmaster_q;

            if (rearb) begin
                beat_cnt_d = '0;
                if (win_found) begin
                    state_d   = OWNED;
                    gnt_d     = NUM_MASTERS'(1) << win_idx;
                    gnt_idx_d = win_idx;
                    rr_ptr_d  = win_idx;
                end else begin
                    state_d   = PARK;
                    gnt_d     = DEF_GNT;
                    gnt_idx_d = DEF_IDX;
                end
            end else if (gnt_idx_q != hmaster_q) begin
                // Address phase is changing hands: the new owner starts fresh.
                beat_cnt_d = '0;
            end else if (beat_valid && !budget_spent) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronous reset: abandons any in-flight tenure and parks the bus.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= PARK;
            gnt_q          <= DEF_GNT;
            gnt_idx_q      <= DEF_IDX;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            rr_ptr_q       <= DEF_IDX;
            beat_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            gnt_idx_q      <= gnt_idx_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            rr_ptr_q       <= rr_ptr_d;
            beat_cnt_q     <= beat_cnt_d;
        end
    end

    assign Bus_Grant    = gnt_q;
    assign HMaster      = hmaster_q;
    assign HMaster_Data = hmaster_data_q;
    assign Parked       = (state_q == PARK);

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (2 masters, 16-beat budget).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ahb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] Bus_Req;
    logic [1:0] HTrans;
    logic       HReady;
    logic [1:0] Bus_Grant;
    logic       HMaster;
    logic       HMaster_Data;
    logic       Parked;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_bus_arbiter #(
        .NUM_MASTERS     (2),
        .DEFAULT_MASTER  (0),
        .MAX_GRANT_BEATS (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Bus_Req      (Bus_Req),
        .HTrans       (HTrans),
        .HReady       (HReady),
        .Bus_Grant    (Bus_Grant),
        .HMaster      (HMaster),
        .HMaster_Data (HMaster_Data),
        .Parked       (Parked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        Bus_Req = 2'b00;
        HTrans  = 2'b00;
        HReady  = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        Bus_Req = 2'b00;
        HTrans  = 2'b00;
        HReady  = 1'b1;
        @(negedge clk);

        // Reset and idle parking
        do_reset();
        check("rst_grant",  Bus_Grant,        2'b01);
        check("rst_hm",     HMaster,          0);
        check("rst_hmd",    HMaster_Data,     0);
        check("rst_parked", Parked,           1);
        check("rst_cnt",    dut.beat_cnt_q,   0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("park_hold", {Bus_Grant, HMaster, HMaster_Data, Parked}, 5'b01_0_0_1);
        end

        // PARK -> DMA: grant, then HMaster, then HMaster_Data one edge apart
        Bus_Req = 2'b10;
        HTrans  = 2'b10;
        step();
        check("p2d_grant",  Bus_Grant,    2'b10);
        check("p2d_parked", Parked,       0);
        check("p2d_hm_e1",  HMaster,      0);
        step();
        check("p2d_hm_e2",  HMaster,      1);
        check("p2d_hmd_e2", HMaster_Data, 0);
        step();
        check("p2d_hmd_e3", HMaster_Data, 1);

        // Budget-driven alternation with both masters requesting
        do_reset();
        Bus_Req = 2'b11;
        HTrans  = 2'b10;
        step();
        check("alt_e1_grant", Bus_Grant, 2'b10);
        HTrans = 2'b11;
        for (int e = 2; e <= 55; e++) begin
            step();
            case (e)
                2:  check("alt_e2_hm",     HMaster,   1);
                3:  check("alt_e3_cnt",    dut.beat_cnt_q, 1);
                18: begin
                    check("alt_e18_grant", Bus_Grant, 2'b10);
                    check("alt_e18_cnt",   dut.beat_cnt_q, 16);
                end
                19: check("alt_e19_grant", Bus_Grant, 2'b01);
                20: begin
                    check("alt_e20_hm",    HMaster,   0);
                    check("alt_e20_cnt",   dut.beat_cnt_q, 0);
                end
                36: begin
                    check("alt_e36_grant", Bus_Grant, 2'b01);
                    check("alt_e36_cnt",   dut.beat_cnt_q, 16);
                end
                37: check("alt_e37_grant", Bus_Grant, 2'b10);
                54: check("alt_e54_grant", Bus_Grant, 2'b10);
                55: check("alt_e55_grant", Bus_Grant, 2'b01);
                default: ;
            endcase
        end

        // Wait states freeze everything while the owner drops its request
        do_reset();
        Bus_Req = 2'b10;
        HTrans  = 2'b11;
        repeat (5) step();
        check("ws_pre_cnt", dut.beat_cnt_q, 3);
        HReady  = 1'b0;
        Bus_Req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ws_grant", Bus_Grant,      2'b10);
            check("ws_hm",    HMaster,        1);
            check("ws_hmd",   HMaster_Data,   1);
            check("ws_cnt",   dut.beat_cnt_q, 3);
        end
        HReady = 1'b1;
        step();
        check("ws_rel_grant",  Bus_Grant,      2'b01);
        check("ws_rel_parked", Parked,         1);
        check("ws_rel_cnt",    dut.beat_cnt_q, 0);
        check("ws_rel_hm",     HMaster,        1);
        step();
        check("ws_rel_hm2",    HMaster,        0);

        // Reset in the middle of a DMA burst
        do_reset();
        Bus_Req = 2'b10;
        HTrans  = 2'b11;
        repeat (9) step();
        check("mid_cnt", dut.beat_cnt_q, 7);
        rst = 1'b1;
        step();
        check("mid_rst_grant",  Bus_Grant,      2'b01);
        check("mid_rst_hm",     HMaster,        0);
        check("mid_rst_hmd",    HMaster_Data,   0);
        check("mid_rst_cnt",    dut.beat_cnt_q, 0);
        check("mid_rst_parked", Parked,         1);
        rst = 1'b0;

        // IDLE transfers never exhaust the budget
        do_reset();
        Bus_Req = 2'b11;
        HTrans  = 2'b00;
        step();
        check("idle_e1_grant", Bus_Grant, 2'b10);
        for (int e = 2; e <= 41; e++) begin
            step();
            if (e % 10 == 1) begin
                check("idle_grant", Bus_Grant,      2'b10);
                check("idle_cnt",   dut.beat_cnt_q, 0);
            end
        end
        Bus_Req = 2'b01;
        step();
        check("idle_drop_grant",  Bus_Grant, 2'b01);
        check("idle_drop_parked", Parked,    0);
        step();
        check("idle_drop_hm",     HMaster,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Round-robin AHB bus arbiter that sits between the requesting masters (CPU, DMA controller) and the shared AHB master-side bus. It drives the Bus_Grant that the DMA controller waits on. It tracks which master owns the address phase and which owns the data phase, so the top level can steer the address/control and write-data multiplexers and route HRData back. It enforces a beat budget per tenure, so a long DMA transfer cannot starve the CPU.

Parameters:
NUM_MASTERS, 2, number of requesting masters (index 0 = CPU, 1 = DMA by convention); legal range 2..8
DEFAULT_MASTER, 0, master that is parked on the bus when nobody requests
MAX_GRANT_BEATS, 16, completed beats allowed per tenure before forced re-arbitration; legal range 1..255

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
Bus_Req  in  NUM_MASTERS  per-master bus request, level-sensitive
HTrans  in  2  HTRANS of the current address-phase owner (muxed)
HReady  in  1  bus HREADY; 1 = current data phase completes this cycle
Bus_Grant  out  NUM_MASTERS  one-hot grant, registered
HMaster  out  $clog2(NUM_MASTERS)  address-phase owner index, registered
HMaster_Data  out  $clog2(NUM_MASTERS)  data-phase owner index, registered (steers HWData mux and HRData return)
Parked  out  1  1 when the bus is parked on DEFAULT_MASTER with no request pending

Behaviour:
- Reset (rst=1 at a clk edge): Bus_Grant = one-hot(DEFAULT_MASTER), HMaster = HMaster_Data = DEFAULT_MASTER, Parked = 1, beat_cnt = 0, rr_ptr = DEFAULT_MASTER, state PARK. This applies mid-burst as well; in-flight transfers are abandoned.
- States:
  - PARK: no tenure in progress.
  - OWNED: a requesting master holds the grant.
- Beat counting:
  - beat_cnt increments at each edge where HReady=1 and HTrans is NONSEQ(2'b10) or SEQ(2'b11).
  - beat_cnt saturates at MAX_GRANT_BEATS.
  - beat_cnt clears to 0 whenever HMaster changes or the same master is re-granted.
  - IDLE and BUSY beats are not counted.
- Re-arbitration point (rearb): HReady=1 AND one of the following:
  - state==PARK;
  - Bus_Req[HMaster]==0;
  - beat_cnt==MAX_GRANT_BEATS.
- No re-arbitration while HReady=0. Bus_Grant, HMaster, HMaster_Data and beat_cnt all hold during wait states.
- Winner selection at rearb is round-robin:
  - Search Bus_Req starting at index (rr_ptr+1) mod NUM_MASTERS and wrap; the first set bit wins. rr_ptr <- winner.
  - If the only requester is the current owner whose budget is exhausted, it is re-granted and beat_cnt clears.
  - If no requester: Bus_Grant <- one-hot(DEFAULT_MASTER), state PARK, Parked=1.
  - Otherwise state OWNED, Parked=0.
- Timing:
  - Bus_Grant updates on the edge following the rearb cycle (1-cycle registered latency).
  - HMaster <- index of Bus_Grant at each edge where HReady=1.
  - HMaster_Data <- HMaster at each edge where HReady=1 (one pipeline stage behind, per AHB address/data overlap).
- Bus_Grant is always exactly one-hot; it is never all-zero.
- Simultaneous requests from PARK with rr_ptr=0: master 1 wins before master 0.
- Owner drops its request and another master raises its request in the same cycle: handover occurs at that cycle's rearb; the new Bus_Grant appears next edge.
- Bus_Req changes on cycles that are not rearb points are ignored until the next rearb.
- Early burst termination through budget expiry is legal. The losing master must re-issue from NONSEQ; the arbiter does not track burst type.

Test Plan:
- Reset with Bus_Req=2'b00, HReady=1 -> Bus_Grant=2'b01, HMaster=0, HMaster_Data=0, Parked=1, held for 10 cycles.
- From PARK, Bus_Req=2'b10 at cycle n, HReady=1 -> Bus_Grant=2'b10 at edge n+1, HMaster=1 at n+2, HMaster_Data=1 at n+3, Parked=0.
- DMA owns the bus, HTrans=NONSEQ then SEQ every cycle, Bus_Req=2'b11, MAX_GRANT_BEATS=16 -> after the 16th counted beat, Bus_Grant=2'b01 next edge. CPU then performs 16 beats and the grant returns to 2'b10; the alternation repeats.
- DMA owns the bus, HReady=0 for 5 cycles while Bus_Req[1] drops -> Bus_Grant, HMaster and beat_cnt frozen. Handover to park occurs on the first HReady=1 cycle, then Bus_Grant=2'b01.
- DMA mid-burst (beat_cnt=7) and rst=1 for one edge -> Bus_Grant=2'b01, HMaster=0, HMaster_Data=0, beat_cnt=0 at that edge.
- Bus_Req=2'b11 with HTrans=IDLE throughout -> beat_cnt stays 0, DMA keeps the grant indefinitely, and the CPU is granted only after Bus_Req[1] drops.
